// File: rtl/adc_sreg_slave.sv
// ----------------------------------------------------------------------------
// adc_sreg_slave
//
// Responder for the ADC 3-wire configuration link (sclk / sload / sdata).
// The link is oversampled on clk: each pin passes through SYNC_STAGES flops
// and one edge-detect flop.  16-bit frames (MSB first) are decoded as
//   bit0 R/W (1 = write), bits1-4 addr, bits5-6 dummy, bits7-15 data[8:0]
// and writes are committed into a 12 x 9-bit register file when sload rises.
//
// Optional feature macro: ADC_SREG_READBACK_EN
//   defined   : read frames shift reg[addr] out on sdo, MSB first, changing
//               on detected sclk falls, with sdo_oe high while driving.
//   undefined : sdo / sdo_oe tied low; read frames are decoded and ignored.
//
// Ports
//   clk           system clock, >= 4x sclk
//   reset_n       synchronous active-low reset
//   sclk          serial clock (asynchronous to clk)
//   sload         frame enable, active-low
//   sdata         serial data in, sampled on sclk rise
//   sdo / sdo_oe  readback data and drive enable
//   regs_flat     register file, reg[n] = regs_flat[9n+8:9n]
//   wr_stb        1-clk pulse per committed write
//   wr_addr/data  address / data of the last committed write
//   frame_err     1-clk pulse on a rejected frame
//   written_mask  bit n set once reg[n] has been written
//   all_written   high one clk after written_mask reaches 12'hFFF
// ----------------------------------------------------------------------------
module adc_sreg_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sclk,
    input  logic         sload,
    input  logic         sdata,
    output logic         sdo,
    output logic         sdo_oe,
    output logic [107:0] regs_flat,
    output logic         wr_stb,
    output logic [3:0]   wr_addr,
    output logic [8:0]   wr_data,
    output logic         frame_err,
    output logic [11:0]  written_mask,
    output logic         all_written
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ADDR  = 4'd11;
    localparam logic [7:0] SETTLE_CNT = 8'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] sload_sync_r;
    logic [SYNC_STAGES-1:0] sdata_sync_r;
    logic                   sclk_det_r;
    logic                   sload_det_r;
    logic [7:0]             settle_r;

    logic                   sclk_s;
    logic                   sload_s;
    logic                   sdata_s;
    logic                   settled_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   sload_rise_s;
    logic                   sload_fall_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [4:0]             bit_cnt_r;
    logic [15:0]            shreg_r;
    logic [15:0]            shift_nxt_s;
    logic [8:0]             regs_r [0:11];

    logic                   commit_wr_s;
    logic                   commit_err_s;
    logic                   frm_rw_s;
    logic [3:0]             frm_addr_s;
    logic [8:0]             frm_data_s;

    // Synchronizer chains: sload idles high, sclk and sdata idle low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_r  <= '0;
            sdata_sync_r <= '0;
            sload_sync_r <= '1;
            sclk_det_r   <= 1'b0;
            sload_det_r  <= 1'b1;
        end else begin
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdata};
            sload_sync_r <= {sload_sync_r[SYNC_STAGES-2:0], sload};
            sclk_det_r   <= sclk_sync_r[SYNC_STAGES-1];
            sload_det_r  <= sload_sync_r[SYNC_STAGES-1];
        end
    end

    // Post-reset settle counter. The sload chain reset value is 1, so a pin
    // that is already low (reset mid-frame) would otherwise appear as a fresh
    // frame start once it propagates; edges are ignored until the chain has
    // been refilled from the pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            settle_r <= 8'd0;
        end else if (settle_r != SETTLE_CNT) begin
            settle_r <= settle_r + 8'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    assign sclk_s       = sclk_sync_r[SYNC_STAGES-1];
    assign sload_s      = sload_sync_r[SYNC_STAGES-1];
    assign sdata_s      = sdata_sync_r[SYNC_STAGES-1];
    assign settled_s    = (settle_r == SETTLE_CNT);
    assign sclk_rise_s  = settled_s &  sclk_s  & ~sclk_det_r;
    assign sclk_fall_s  = settled_s & ~sclk_s  &  sclk_det_r;
    assign sload_rise_s = settled_s &  sload_s & ~sload_det_r;
    assign sload_fall_s = settled_s & ~sload_s &  sload_det_r;

    assign shift_nxt_s  = {shreg_r[14:0], sdata_s};
    assign frm_rw_s     = shreg_r[15];
    assign frm_addr_s   = shreg_r[14:11];
    assign frm_data_s   = shreg_r[8:0];

    // Frame FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sload_fall_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (sload_rise_s) begin
                    state_nxt_s = IDLE;
                end else if (sclk_rise_s && (bit_cnt_r == 5'd15)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (sload_rise_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Frame-end decode: short frames and out-of-range addresses are rejected.
    always_comb begin
        commit_wr_s  = 1'b0;
        commit_err_s = 1'b0;
        if (sload_rise_s && (state_r != IDLE)) begin
            if (bit_cnt_r < 5'd16) begin
                commit_err_s = 1'b1;
            end else if (frm_addr_s > LAST_ADDR) begin
                commit_err_s = 1'b1;
            end else if (frm_rw_s) begin
                commit_wr_s = 1'b1;
            end else begin
                commit_wr_s = 1'b0;
            end
        end else begin
            commit_wr_s  = 1'b0;
            commit_err_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bit counter and input shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_r <= 5'd0;
            shreg_r   <= 16'd0;
        end else if ((state_r == IDLE) && sload_fall_s) begin
            bit_cnt_r <= 5'd0;
            shreg_r   <= 16'd0;
        end else if ((state_r == SHIFT) && !sload_rise_s && sclk_rise_s) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
            shreg_r   <= shift_nxt_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shreg_r   <= shreg_r;
        end
    end

    // Register file, write status and commit strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < 12; n++) begin
                regs_r[n] <= 9'd0;
            end
            written_mask <= 12'd0;
            wr_addr      <= 4'd0;
            wr_data      <= 9'd0;
            wr_stb       <= 1'b0;
            frame_err    <= 1'b0;
            all_written  <= 1'b0;
        end else begin
            wr_stb      <= commit_wr_s;
            frame_err   <= commit_err_s;
            all_written <= (written_mask == 12'hFFF);
            if (commit_wr_s) begin
                regs_r[frm_addr_s]       <= frm_data_s;
                written_mask[frm_addr_s] <= 1'b1;
                wr_addr                  <= frm_addr_s;
                wr_data                  <= frm_data_s;
            end else begin
                wr_addr <= wr_addr;
                wr_data <= wr_data;
            end
        end
    end

    // Flatten the register file onto the output bus.
    always_comb begin
        regs_flat = 108'd0;
        for (int n = 0; n < 12; n++) begin
            regs_flat[9*n +: 9] = regs_r[n];
        end
    end

`ifdef ADC_SREG_READBACK_EN
    logic [8:0] out_sh_r;
    logic       rd_active_r;

    // Readback shifter. By the 7th rise, R/W and addr are fully shifted in
    // (they sit in shift_nxt_s[6:2]), so the selected register is loaded then
    // and presented one bit per detected sclk fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_sh_r    <= 9'd0;
            rd_active_r <= 1'b0;
            sdo         <= 1'b0;
            sdo_oe      <= 1'b0;
        end else if (sload_rise_s) begin
            out_sh_r    <= 9'd0;
            rd_active_r <= 1'b0;
            sdo         <= 1'b0;
            sdo_oe      <= 1'b0;
        end else if ((state_r == SHIFT) && sclk_rise_s && (bit_cnt_r == 5'd6)
                     && !shift_nxt_s[6] && (shift_nxt_s[5:2] <= LAST_ADDR)) begin
            out_sh_r    <= regs_r[shift_nxt_s[5:2]];
            rd_active_r <= 1'b1;
        end else if (rd_active_r && sclk_fall_s) begin
            sdo_oe   <= 1'b1;
            sdo      <= out_sh_r[8];
            out_sh_r <= {out_sh_r[7:0], 1'b0};
        end else begin
            out_sh_r    <= out_sh_r;
            rd_active_r <= rd_active_r;
        end
    end
`else
    assign sdo    = 1'b0;
    assign sdo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sreg_slave.sv
// ----------------------------------------------------------------------------
// tb_adc_sreg_slave
//
// Directed bench for adc_sreg_slave. Frames are bit-banged with sclk half
// periods of 8 clk; commit pulses are counted by a negedge monitor and
// compared as per-frame deltas against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_adc_sreg_slave;

    logic         clk;
    logic         reset_n;
    logic         sclk;
    logic         sload;
    logic         sdata;
    logic         sdo;
    logic         sdo_oe;
    logic [107:0] regs_flat;
    logic         wr_stb;
    logic [3:0]   wr_addr;
    logic [8:0]   wr_data;
    logic         frame_err;
    logic [11:0]  written_mask;
    logic         all_written;

    int checks_done;
    int checks_failed;

    int stb_total;
    int err_total;
    int both_total;
    int oe_total;
    logic stb_prev;
    logic aw_at_stb;
    logic aw_after_stb;

    int stb_delta;
    int err_delta;
    int oe_delta;
    logic [8:0] rd_bits;
    logic oe_at_rise8;

    adc_sreg_slave #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sclk         (sclk),
        .sload        (sload),
        .sdata        (sdata),
        .sdo          (sdo),
        .sdo_oe       (sdo_oe),
        .regs_flat    (regs_flat),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_err    (frame_err),
        .written_mask (written_mask),
        .all_written  (all_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    initial begin
        stb_total = 0; err_total = 0; both_total = 0; oe_total = 0;
        stb_prev = 1'b0; aw_at_stb = 1'b0; aw_after_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (stb_prev) aw_after_stb = all_written;
            if (wr_stb) begin
                stb_total++;
                aw_at_stb = all_written;
            end
            if (frame_err) err_total++;
            if (wr_stb && frame_err) both_total++;
            if (sdo_oe) oe_total++;
            stb_prev = wr_stb;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_done++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive sload low, nrise sclk pulses (bits MSB first, zeros past bit 15),
    // then sload high and wait for the commit to settle.
    task automatic send_frame(input logic [15:0] frame, input int nrise);
        int s0, e0, o0;
        s0 = stb_total; e0 = err_total; o0 = oe_total;
        rd_bits = 9'd0;
        oe_at_rise8 = 1'b0;
        @(negedge clk);
        sload = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            sdata = (i < 16) ? frame[15-i] : 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            if (i >= 7 && i <= 15) rd_bits = {rd_bits[7:0], sdo};
            if (i == 7) oe_at_rise8 = sdo_oe;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        sload = 1'b1;
        repeat (12) @(negedge clk);
        stb_delta = stb_total - s0;
        err_delta = err_total - e0;
        oe_delta  = oe_total - o0;
    endtask

    logic [107:0] exp_regs;
    logic [107:0] snap_regs;
    int s0, e0;

    initial begin
        checks_done = 0;
        checks_failed = 0;
        reset_n = 1'b0;
        sclk = 1'b0;
        sload = 1'b1;
        sdata = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_regs", regs_flat, 108'd0);
        check_val("rst_mask", written_mask, 12'd0);
        check_val("rst_outs", {all_written, wr_stb, frame_err, sdo, sdo_oe, wr_addr, wr_data},
                  {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 9'd0});
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Write 0x0A5 to addr 3, with the master's trailing 17th edge.
        send_frame({1'b1, 4'd3, 2'b00, 9'h0A5}, 17);
        check_val("w3_stb", stb_delta, 1);
        check_val("w3_err", err_delta, 0);
        check_val("w3_addr", wr_addr, 4'd3);
        check_val("w3_data", wr_data, 9'h0A5);
        check_val("w3_reg", regs_flat[35:27], 9'h0A5);
        check_val("w3_mask", written_mask, 12'h008);

        // Read back addr 3.
        send_frame({1'b0, 4'd3, 2'b00, 9'h000}, 17);
        check_val("rd_stb", stb_delta, 0);
        check_val("rd_err", err_delta, 0);
        check_val("rd_oe_end", sdo_oe, 1'b0);
`ifdef ADC_SREG_READBACK_EN
        check_val("rd_bits", rd_bits, 9'h0A5);
        check_val("rd_oe_r8", oe_at_rise8, 1'b1);
`else
        check_val("rd_oe_seen", oe_delta, 0);
`endif

        // Aborted after 9 bits: error, no write, registers untouched.
        snap_regs = regs_flat;
        send_frame({1'b1, 4'd5, 2'b00, 9'h1FF}, 9);
        check_val("abort_err", err_delta, 1);
        check_val("abort_stb", stb_delta, 0);
        check_val("abort_regs", regs_flat, snap_regs);

        // Write to out-of-range addr 13.
        send_frame({1'b1, 4'd13, 2'b00, 9'h055}, 17);
        check_val("a13_err", err_delta, 1);
        check_val("a13_stb", stb_delta, 0);
        check_val("a13_regs", regs_flat, snap_regs);
        check_val("a13_mask", written_mask, 12'h008);

        // Read of out-of-range addr 12: error, never drives.
        send_frame({1'b0, 4'd12, 2'b00, 9'h000}, 17);
        check_val("r12_err", err_delta, 1);
        check_val("r12_oe", oe_delta, 0);

        // Full 12-register init, values 0x101..0x10C.
        s0 = stb_total;
        e0 = err_total;
        exp_regs = 108'd0;
        for (int a = 0; a < 12; a++) begin
            logic [8:0] v;
            v = 9'h101 + 9'(a);
            exp_regs[9*a +: 9] = v;
            send_frame({1'b1, 4'(a), 2'b11, v}, 17);
        end
        check_val("init_stb", stb_total - s0, 12);
        check_val("init_err", err_total - e0, 0);
        check_val("init_regs", regs_flat, exp_regs);
        check_val("init_mask", written_mask, 12'hFFF);
        check_val("init_aw_at", aw_at_stb, 1'b0);
        check_val("init_aw_after", aw_after_stb, 1'b1);
        check_val("init_last", {wr_addr, wr_data}, {4'd11, 9'h10C});

        // Reset mid-frame at bit 10.
        s0 = stb_total;
        e0 = err_total;
        @(negedge clk);
        sload = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            sdata = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            if (i == 9) begin
                reset_n = 1'b0;
                @(negedge clk);
                check_val("mid_regs", regs_flat, 108'd0);
                check_val("mid_mask", written_mask, 12'd0);
                check_val("mid_outs", {all_written, wr_stb, frame_err, sdo, sdo_oe, wr_addr, wr_data},
                          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 9'd0});
                reset_n = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        sload = 1'b1;
        repeat (12) @(negedge clk);
        check_val("mid_rest_stb", stb_total - s0, 0);
        check_val("mid_rest_err", err_total - e0, 0);

        // Next full frame commits normally.
        send_frame({1'b1, 4'd7, 2'b01, 9'h13C}, 17);
        check_val("post_stb", stb_delta, 1);
        check_val("post_err", err_delta, 0);
        check_val("post_reg", regs_flat[71:63], 9'h13C);
        check_val("post_mask", written_mask, 12'h080);
        check_val("post_aw", all_written, 1'b0);

        check_val("stb_err_excl", both_total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
